// File: rtl/sel_ctrl_if.sv
// Handshake bundle between the select generator and its consumer.
// Carries the raw button, mode request and the registered select outputs.
interface sel_ctrl_if;
   logic btn;
   logic auto_en;
   logic sel;
   logic sel_pulse;
   logic btn_db;

   modport master (
      output btn,
      output auto_en,
      input  sel,
      input  sel_pulse,
      input  btn_db
   );

   modport slave (
      input  btn,
      input  auto_en,
      output sel,
      output sel_pulse,
      output btn_db
   );
endinterface

// File: rtl/sel_ctrl.sv
// Mux select generator: synchronised, debounced button toggles sel,
// with an optional fixed-period auto-toggle mode.
module sel_ctrl #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int AUTO_PERIOD     = 8
) (
   input logic        clk,
   input logic        rst_n,
   sel_ctrl_if.slave  bus
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam int PW = $clog2(AUTO_PERIOD);
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [PW-1:0] P_LAST  = PW'(AUTO_PERIOD - 1);

   typedef enum logic {
      MANUAL = 1'b0,
      AUTO   = 1'b1
   } state_t;

   state_t        state;
   logic          s1;
   logic          s2;
   logic [DW-1:0] dcnt;
   logic          db;
   logic          db_q;
   logic [PW-1:0] pcnt;
   logic          sel_q;
   logic          pulse_q;
   logic          press;

   assign press         = db & ~db_q;
   assign bus.sel       = sel_q;
   assign bus.sel_pulse = pulse_q;
   assign bus.btn_db    = db;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= bus.btn;
         s2 <= s1;
      end
   end

   // Any return to the current level restarts the stability count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dcnt <= '0;
         db   <= 1'b0;
         db_q <= 1'b0;
      end else begin
         db_q <= db;
         if (s2 == db) begin
            dcnt <= '0;
         end else if (dcnt == DB_LAST) begin
            db   <= s2;
            dcnt <= '0;
         end else begin
            dcnt <= dcnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= MANUAL;
         pcnt    <= '0;
         sel_q   <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         pulse_q <= 1'b0;
         unique case (state)
            MANUAL: begin
               if (press) begin
                  sel_q   <= ~sel_q;
                  pulse_q <= 1'b1;
               end
               if (bus.auto_en) begin
                  state <= AUTO;
                  pcnt  <= '0;
               end
            end
            AUTO: begin
               if (!bus.auto_en) begin
                  state <= MANUAL;
                  pcnt  <= '0;
                  if (press) begin
                     sel_q   <= ~sel_q;
                     pulse_q <= 1'b1;
                  end
               end else if (press || pcnt == P_LAST) begin
                  // Press and terminal count together still give one toggle.
                  sel_q   <= ~sel_q;
                  pulse_q <= 1'b1;
                  pcnt    <= '0;
               end else begin
                  pcnt <= pcnt + 1'b1;
               end
            end
            default: begin
               state <= MANUAL;
               pcnt  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sel_ctrl.sv
// Directed bench for sel_ctrl: vector table plus bounce, collision
// and asynchronous reset sequences.
module tb_sel_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;
   int   npul  = 0;
   int   dbchg = 0;
   logic dbprev;

   always #5 clk = ~clk;

   sel_ctrl_if bus();

   sel_ctrl #(
      .DEBOUNCE_CYCLES(16),
      .AUTO_PERIOD(8)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus.slave)
   );

   typedef struct {
      logic btn;
      logic auto_en;
      int   cyc;
      logic sel;
      logic pul;
      logic db;
      int   np;
   } vec_t;

   vec_t tv[19];

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", nm, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         if (bus.sel_pulse) npul++;
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // btn, auto_en, cycles, sel, sel_pulse, btn_db, pulses in window
      tv[0]  = '{1'b0, 1'b0,  3, 1'b0, 1'b0, 1'b0, 0};
      tv[1]  = '{1'b1, 1'b0, 17, 1'b0, 1'b0, 1'b0, 0};
      tv[2]  = '{1'b1, 1'b0,  1, 1'b0, 1'b0, 1'b1, 0};
      tv[3]  = '{1'b1, 1'b0,  1, 1'b1, 1'b1, 1'b1, 1};
      tv[4]  = '{1'b1, 1'b0,  1, 1'b1, 1'b0, 1'b1, 0};
      tv[5]  = '{1'b1, 1'b0, 21, 1'b1, 1'b0, 1'b1, 0};
      tv[6]  = '{1'b0, 1'b0, 17, 1'b1, 1'b0, 1'b1, 0};
      tv[7]  = '{1'b0, 1'b0,  1, 1'b1, 1'b0, 1'b0, 0};
      tv[8]  = '{1'b0, 1'b0,  3, 1'b1, 1'b0, 1'b0, 0};
      tv[9]  = '{1'b0, 1'b1,  1, 1'b1, 1'b0, 1'b0, 0};
      tv[10] = '{1'b0, 1'b1,  7, 1'b1, 1'b0, 1'b0, 0};
      tv[11] = '{1'b0, 1'b1,  1, 1'b0, 1'b1, 1'b0, 1};
      tv[12] = '{1'b0, 1'b1,  1, 1'b0, 1'b0, 1'b0, 0};
      tv[13] = '{1'b0, 1'b1,  6, 1'b0, 1'b0, 1'b0, 0};
      tv[14] = '{1'b0, 1'b1,  1, 1'b1, 1'b1, 1'b0, 1};
      tv[15] = '{1'b0, 1'b1, 16, 1'b1, 1'b1, 1'b0, 2};
      tv[16] = '{1'b0, 1'b1,  8, 1'b0, 1'b1, 1'b0, 1};
      tv[17] = '{1'b0, 1'b0,  1, 1'b0, 1'b0, 1'b0, 0};
      tv[18] = '{1'b0, 1'b0, 20, 1'b0, 1'b0, 1'b0, 0};

      rst_n       = 1'b0;
      bus.btn     = 1'b0;
      bus.auto_en = 1'b0;
      #23;
      check("rst_sel", bus.sel, 1'b0);
      check("rst_pulse", bus.sel_pulse, 1'b0);
      check("rst_db", bus.btn_db, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      step(1);

      for (int i = 0; i < 19; i++) begin
         npul        = 0;
         bus.btn     = tv[i].btn;
         bus.auto_en = tv[i].auto_en;
         step(tv[i].cyc);
         check($sformatf("row%0d_sel", i), bus.sel, tv[i].sel);
         check($sformatf("row%0d_pulse", i), bus.sel_pulse, tv[i].pul);
         check($sformatf("row%0d_db", i), bus.btn_db, tv[i].db);
         check($sformatf("row%0d_npulse", i), npul, tv[i].np);
      end

      // bouncing button never settles for 16 cycles
      npul   = 0;
      dbchg  = 0;
      dbprev = bus.btn_db;
      for (int k = 0; k < 10; k++) begin
         bus.btn = (k % 2 == 0);
         for (int c = 0; c < 3; c++) begin
            step(1);
            if (bus.btn_db !== dbprev) dbchg++;
            dbprev = bus.btn_db;
         end
      end
      check("bounce_db_changes", dbchg, 0);
      check("bounce_npulse", npul, 0);
      bus.btn = 1'b1;
      step(18);
      check("bounce_sel_pre", bus.sel, 1'b0);
      step(1);
      check("bounce_sel", bus.sel, 1'b1);
      check("bounce_pulse", bus.sel_pulse, 1'b1);
      check("bounce_npulse_one", npul, 1);
      bus.btn = 1'b0;
      step(20);
      check("bounce_rel_db", bus.btn_db, 1'b0);
      check("bounce_rel_sel", bus.sel, 1'b1);

      // press lands on the auto terminal-count edge
      npul    = 0;
      bus.btn = 1'b1;
      step(2);
      bus.auto_en = 1'b1;
      step(9);
      check("col_first_auto", bus.sel, 1'b0);
      check("col_np1", npul, 1);
      step(7);
      check("col_pre", bus.sel, 1'b0);
      step(1);
      check("col_sel", bus.sel, 1'b1);
      check("col_pulse", bus.sel_pulse, 1'b1);
      check("col_np2", npul, 2);
      step(7);
      check("col_hold", bus.sel, 1'b1);
      check("col_np_hold", npul, 2);
      step(1);
      check("col_next_auto", bus.sel, 1'b0);
      check("col_next_pulse", bus.sel_pulse, 1'b1);
      step(8);
      check("col_auto3", bus.sel, 1'b1);

      // asynchronous reset mid-period and mid-release-debounce
      bus.btn = 1'b0;
      step(5);
      check("pre_rst_sel", bus.sel, 1'b1);
      check("pre_rst_db", bus.btn_db, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_sel", bus.sel, 1'b0);
      check("arst_pulse", bus.sel_pulse, 1'b0);
      check("arst_db", bus.btn_db, 1'b0);
      bus.auto_en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      npul  = 0;
      step(30);
      check("post_rst_sel", bus.sel, 1'b0);
      check("post_rst_db", bus.btn_db, 1'b0);
      check("post_rst_npulse", npul, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sel_ctrl.md
# sel_ctrl

Select-signal generator that drives the `sel` input of the 2:1 `mux` stage directly downstream. It synchronises and debounces a raw push-button, toggles `sel` once per debounced press, and optionally toggles `sel` automatically at a fixed period. `sel` is a clean, registered, glitch-free level suitable for feeding the mux select.

## Interface
- `DEBOUNCE_CYCLES`, default 16: stable cycles required before the debounced level changes; legal range is at least 2.
- `AUTO_PERIOD`, default 8: cycles between automatic toggles in AUTO mode; legal range is at least 2.
- `clk`  input  1  single clock. All logic is rising-edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `btn`  input  1  raw button, asynchronous to `clk`, may bounce.
- `auto_en`  input  1  synchronous to `clk`. 1 selects AUTO mode; 0 selects MANUAL mode.
- `sel`  output  1  registered select to the downstream mux. 0 selects `a`; 1 selects `b`.
- `sel_pulse`  output  1  registered; high for exactly one cycle after each `sel` change.
- `btn_db`  output  1  registered debounced button level.

## Operation
- **Reset:** `rst_n` low immediately clears all of the following, regardless of `clk`, including mid-count or mid-debounce:
  - `sel`, `sel_pulse`, `btn_db` to 0
  - sync flops `s1`/`s2` to 0
  - debounce counter and period counter to 0
  - state to MANUAL
- **Synchroniser:** two flops, `btn`→`s1`→`s2`.
- **Debounce:**
  - Counter width is $clog2(DEBOUNCE_CYCLES).
  - If `s2 == btn_db`, the counter clears to 0.
  - Otherwise, if counter == DEBOUNCE_CYCLES-1: `btn_db <= s2` and the counter clears.
  - Otherwise the counter increments.
  - Any bounce back to `btn_db` restarts the count from 0.
- **Press event:** `press = btn_db & ~btn_db_q`, where `btn_db_q` is `btn_db` delayed one cycle. Only the rising edge counts; release never toggles.
- **State machine:**
  - MANUAL → AUTO when `auto_en` = 1; the period counter is loaded with 0.
  - AUTO → MANUAL when `auto_en` = 0; `sel` is held and the period counter is cleared.
- **MANUAL:** `press` toggles `sel`.
- **AUTO:**
  - The period counter (width $clog2(AUTO_PERIOD)) increments each cycle.
  - At AUTO_PERIOD-1 it wraps to 0 and `sel` toggles.
  - `press` also toggles `sel` and reloads the counter with 0.
  - If `press` and terminal count occur in the same cycle: exactly one toggle, counter reloads 0.
- **Toggle limit:** `sel` changes at most once per cycle.
- **`sel_pulse`:** set to 1 on the edge where `sel` changes, otherwise 0.

## Timing
- **Button latency:** `btn` stable high, first sampled by `s1` at edge N.
  - `s2` = 1 after edge N+1.
  - `btn_db` = 1 after edge N+1+DEBOUNCE_CYCLES.
  - `sel` toggles and `sel_pulse` = 1 after edge N+2+DEBOUNCE_CYCLES.
  - With the default of 16, that is edge N+18.
- **`sel_pulse` width:** exactly one cycle; low again after the following edge.
- **AUTO entry:** `auto_en` sampled 1 at edge M (state becomes AUTO, counter 0). The first toggle is at edge M+AUTO_PERIOD, then every AUTO_PERIOD edges.
- **Mode change:** `auto_en` deasserts at edge M; no toggle from edge M onward unless a `press` occurs.
- **Reset release:** the first edge with `rst_n` high behaves as normal operation from the all-zero state.

## Test plan
- **Reset:** assert `rst_n`=0 asynchronously mid-debounce and mid-period.
  - Required: `sel`=`sel_pulse`=`btn_db`=0 immediately, without waiting for a clock edge.
  - Required: after release, no toggle unless new stimulus is applied.
- **Clean press, DEBOUNCE_CYCLES=16, MANUAL:**
  - Stimulus: `btn` 0→1, held 40 cycles, then released.
  - Required: `sel` 0→1 exactly 18 edges after the first sample; `sel_pulse` high for 1 cycle.
  - Required: release causes no change.
- **Bouncy press:** `btn` toggles every 3 cycles for 30 cycles, then stays high.
  - Required: no `btn_db` change during bouncing.
  - Required: a single `sel` toggle 18 edges after the final stable sample.
- **AUTO, AUTO_PERIOD=8:** `auto_en`=1 for 40 cycles.
  - Required: `sel` toggles at entry+8, +16, +24, +32, +40 (5 `sel_pulse`s).
  - Required: after `auto_en`=0, `sel` holds.
- **Collision:** in AUTO, time `press` onto the terminal-count cycle.
  - Required: exactly one toggle and one `sel_pulse`.
  - Required: the next auto toggle is 8 cycles later.
